// File: rtl/ahb_to_apb_bridge.sv
// AHB-Lite slave to APB requester bridge: one outstanding transfer,
// registered outputs, slave-error / timeout mapped to a two-cycle ERROR.
module ahb_to_apb_bridge #(
    parameter int DATA_WIDTH  = 32,
    parameter int PADDR_WIDTH = 16,
    parameter int TIMEOUT     = 255
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic                   HSEL,
    input  logic [31:0]            HADDR,
    input  logic [1:0]             HTRANS,
    input  logic                   HWRITE,
    input  logic [2:0]             HSIZE,
    input  logic [DATA_WIDTH-1:0]  HWDATA,
    input  logic                   HREADY,
    output logic [DATA_WIDTH-1:0]  HRDATA,
    output logic                   HRESP,
    output logic                   HREADYOUT,
    output logic [PADDR_WIDTH-1:0] PADDR,
    output logic                   PSEL,
    output logic                   PENABLE,
    output logic                   PWRITE,
    output logic [DATA_WIDTH-1:0]  PWDATA,
    input  logic [DATA_WIDTH-1:0]  PRDATA,
    input  logic                   PREADY,
    input  logic                   PSLVERR
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_SETUP,
        S_ACCESS,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t                   r_state;
    logic [CW-1:0]            r_wait_cnt;
    logic [DATA_WIDTH-1:0]    r_hrdata;
    logic                     r_hresp;
    logic                     r_hreadyout;
    logic [PADDR_WIDTH-1:0]   r_paddr;
    logic                     r_psel;
    logic                     r_penable;
    logic                     r_pwrite;
    logic [DATA_WIDTH-1:0]    r_pwdata;

    logic w_accept;
    logic w_size_ok;
    logic w_unused;

    assign w_accept  = HSEL && HTRANS[1] && HREADY;
    assign w_size_ok = (HSIZE == 3'b010);
    assign w_unused  = ^{HADDR[31:PADDR_WIDTH], HTRANS[0]};

    assign HRDATA    = r_hrdata;
    assign HRESP     = r_hresp;
    assign HREADYOUT = r_hreadyout;
    assign PADDR     = r_paddr;
    assign PSEL      = r_psel;
    assign PENABLE   = r_penable;
    assign PWRITE    = r_pwrite;
    assign PWDATA    = r_pwdata;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state     <= S_IDLE;
            r_wait_cnt  <= '0;
            r_hrdata    <= '0;
            r_hresp     <= 1'b0;
            r_hreadyout <= 1'b1;
            r_paddr     <= '0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= '0;
        end else begin
            unique case (r_state)
                // ERR2 is the ready half of an error response, so it accepts too
                S_IDLE, S_ERR2: begin
                    r_state     <= S_IDLE;
                    r_hresp     <= 1'b0;
                    r_hreadyout <= 1'b1;
                    if (w_accept) begin
                        r_paddr     <= HADDR[PADDR_WIDTH-1:0];
                        r_pwrite    <= HWRITE;
                        r_hreadyout <= 1'b0;
                        if (w_size_ok) begin
                            r_state <= S_LATCH;
                        end else begin
                            r_state <= S_ERR1;
                            r_hresp <= 1'b1;
                        end
                    end
                end
                S_LATCH: begin
                    if (r_pwrite) begin
                        r_pwdata <= HWDATA;
                    end
                    r_psel  <= 1'b1;
                    r_state <= S_SETUP;
                end
                S_SETUP: begin
                    r_penable  <= 1'b1;
                    r_wait_cnt <= '0;
                    r_state    <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (PREADY) begin
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        if (PSLVERR) begin
                            r_state <= S_ERR1;
                            r_hresp <= 1'b1;
                        end else begin
                            r_state     <= S_IDLE;
                            r_hreadyout <= 1'b1;
                            if (!r_pwrite) begin
                                r_hrdata <= PRDATA;
                            end
                        end
                    end else if (r_wait_cnt == LAST_WAIT) begin
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_state   <= S_ERR1;
                        r_hresp   <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CW'(1);
                    end
                end
                S_ERR1: begin
                    r_hreadyout <= 1'b1;
                    r_state     <= S_ERR2;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ahb_to_apb_bridge.md
AHB_TO_APB_BRIDGE -- requirements
Module: ahb_to_apb_bridge

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 32, AHB/APB data width; PADDR_WIDTH, 16, APB address width (HADDR low bits); TIMEOUT, 255, maximum PREADY-low cycles in ACCESS.
REQ-002 Ports SHALL be (name direction width meaning):
- HCLK in 1 clock; all logic on rising edge
- HRESET in 1 asynchronous, active-high reset
- HSEL in 1 slave select from decoder
- HADDR in 32 AHB address
- HTRANS in 2 AHB transfer type
- HWRITE in 1 1=write
- HSIZE in 3 transfer size
- HWDATA in DATA_WIDTH write data
- HREADY in 1 bus-level ready (from response mux)
- HRDATA out DATA_WIDTH read data to response mux
- HRESP out 1 0=OKAY, 1=ERROR
- HREADYOUT out 1 slave ready to response mux
- PADDR out PADDR_WIDTH APB address
- PSEL out 1 APB select
- PENABLE out 1 APB enable
- PWRITE out 1 APB direction
- PWDATA out DATA_WIDTH APB write data
- PRDATA in DATA_WIDTH APB read data
- PREADY in 1 APB ready
- PSLVERR in 1 APB error
REQ-003 All outputs SHALL be registered; no combinational path from any input to any output.

Function
REQ-004 FSM states SHALL be IDLE, LATCH, SETUP, ACCESS, ERR1, ERR2.
REQ-005 Accept condition SHALL be HSEL=1, HTRANS[1]=1 (NONSEQ/SEQ) and HREADY=1, sampled only in IDLE or ERR2; IDLE/BUSY transfers and deselected cycles SHALL be ignored with OKAY response.
REQ-006 On accept: HADDR[PADDR_WIDTH-1:0] captured to PADDR, HWRITE to PWRITE; next cycle HREADYOUT=0.
REQ-007 Accepted transfer with HSIZE != 3'b010 SHALL go directly to ERR1 with no APB access.
REQ-008 LATCH (1 cycle, HREADYOUT=0): HWDATA captured into PWDATA at end of cycle (writes only; reads leave PWDATA unchanged); next state SETUP.
REQ-009 SETUP (1 cycle): PSEL=1, PENABLE=0; next state ACCESS.
REQ-010 ACCESS: PSEL=1, PENABLE=1; PADDR, PWRITE and PWDATA held stable; wait while PREADY=0.
REQ-011 ACCESS with PREADY=1, PSLVERR=0: next cycle IDLE, PSEL=PENABLE=0, HREADYOUT=1, HRESP=0, HRDATA=PRDATA for reads (unchanged for writes).
REQ-012 ACCESS with PREADY=1, PSLVERR=1: next state ERR1; PSEL=PENABLE=0.
REQ-013 Wait counter SHALL count consecutive PREADY=0 cycles in ACCESS; reaching TIMEOUT SHALL abort (PSEL=PENABLE=0) and enter ERR1; counter clears on entry to ACCESS.
REQ-014 Error response SHALL be two-cycle: ERR1 HRESP=1, HREADYOUT=0; ERR2 HRESP=1, HREADYOUT=1; then IDLE, unless a new transfer is accepted in ERR2 (-> LATCH, or ERR1 if HSIZE invalid).
REQ-015 Zero-wait APB transfer latency SHALL be exactly 3 AHB wait states (HREADYOUT low 3 cycles: LATCH, SETUP, ACCESS); each PREADY=0 cycle adds one.
REQ-016 Back-to-back: transfer presented in cycle HREADYOUT returns to 1 SHALL be accepted with no idle gap.
REQ-017 HTRANS/HSEL changes while HREADYOUT=0 SHALL be ignored.

Reset
REQ-018 HRESET=1 SHALL asynchronously force IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, wait counter=0.
REQ-019 Reset asserted mid-transfer (any state) SHALL abort immediately with no further APB phase; first accept after release SHALL be possible in the first cycle after HRESET deasserts.

Verification
REQ-020 Write HADDR=0x0000_0104, HWDATA=0xDEAD_BEEF, PREADY=1 -> SETUP with PADDR=0x0104, PWRITE=1, PWDATA=0xDEADBEEF; HREADYOUT low exactly 3 cycles, HRESP=0.
REQ-021 Read 0x0008, PREADY low 2 cycles then high with PRDATA=0x1234_5678 -> HREADYOUT low 5 cycles, then HRDATA=0x12345678, HRESP=0.
REQ-022 Write with PSLVERR=1 on PREADY -> ERR1 (HRESP=1, HREADYOUT=0), ERR2 (HRESP=1, HREADYOUT=1), then OKAY/ready.
REQ-023 HSIZE=3'b000 transfer -> PSEL never asserted, two-cycle ERROR response.
REQ-024 PREADY held 0, TIMEOUT=4 -> PENABLE dropped after 4 wait cycles, two-cycle ERROR response.
REQ-025 Two back-to-back NONSEQ writes, second presented in completion cycle; plus HRESET pulse in ACCESS -> second accepted with no gap; reset forces PSEL=0, HREADYOUT=1 same cycle.
